// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to reject an access before touching the RAM.

`ifndef MEM_LSU_DEFINES
`define MEM_LSU_DEFINES
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`define SIZE_B    2'b00
`define SIZE_H    2'b01
`define SIZE_W    2'b10
`define LSU_IDLE  2'b00
`define LSU_READ  2'b01
`define LSU_WRITE 2'b10
`define LSU_RESP  2'b11
`endif

package mem_lsu_pkg;

    localparam logic [1:0] SIZE_B = `SIZE_B;
    localparam logic [1:0] SIZE_H = `SIZE_H;
    localparam logic [1:0] SIZE_W = `SIZE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = `LSU_IDLE,
        ST_READ  = `LSU_READ,
        ST_WRITE = `LSU_WRITE,
        ST_RESP  = `LSU_RESP
    } lsu_state_t;

    // An access is rejected when its size is the reserved code or when the
    // byte offset does not sit on a natural boundary for that size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = off[0];
            SIZE_W:  err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Big-endian lane steering for a 32-bit word: pulls a byte/half/word out of
// a line (with sign or zero extension) and merges store data into a line.
// Offset 0 is the most significant lane.

module mem_lane
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_line,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit position of the selected lane: offset 0 sits at the top of the word.
    assign w_bsh  = {~i_off, 3'b000};
    assign w_hsh  = {~i_off[1], 4'b0000};
    assign w_byte = i_line[w_bsh +: 8];
    assign w_half = i_line[w_hsh +: 16];

    // Extract the load value and build the merged store word for the lane.
    always_comb begin
        o_load  = i_line;
        o_store = i_wdata;
        case (i_size)
            SIZE_B: begin
                o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_store = i_line;
                o_store[w_bsh +: 8] = i_wdata[7:0];
            end
            SIZE_H: begin
                o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_store = i_line;
                o_store[w_hsh +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load  = i_line;
                o_store = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the single-port word-wide data RAM. One access
// in flight at a time; sub-word stores are done as read-modify-write.
// Request handshake: a request is taken on a rising edge where req_valid_i
// and req_ready_o are both high; req_ready_o is high only in IDLE, and a
// request presented at any other time is neither taken nor acknowledged.
// Only DATA_WIDTH = 32 is supported.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t            r_state;
    logic                  r_ready;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_line;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_store;
    logic                  w_err;

    assign w_err = access_err(req_size_i, req_addr_i[1:0]);

    mem_lane u_lane (
        .i_line     (mem_rdata_i),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_store    (w_store)
    );

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    // r_line holds the word to write; it is only presented while writing.
    assign mem_wdata_o = r_mem_we ? r_line : '0;

    // Access sequencer: accept, optional read, optional write, one-cycle response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_line      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_ready    <= 1'b0;
                        r_we       <= req_we_i;
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        r_off      <= req_addr_i[1:0];
                        r_wdata    <= req_wdata_i;
                        if (w_err) begin
                            // Rejected access: respond at once, RAM untouched.
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_mem_addr <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            if (req_we_i && (req_size_i == SIZE_W)) begin
                                // Full-word store needs no read of the old line.
                                r_state  <= ST_WRITE;
                                r_mem_we <= 1'b1;
                                r_line   <= req_wdata_i;
                            end else begin
                                r_state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        // Sub-word store: capture the old line with new lane(s) merged in.
                        r_state  <= ST_WRITE;
                        r_mem_we <= 1'b1;
                        r_line   <= w_store;
                    end else begin
                        r_state     <= ST_RESP;
                        r_line      <= mem_rdata_i;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load;
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_RESP;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 64-word RAM model on the memory port, directed cases
// for the documented scenarios, then randomized traffic checked against a
// behavioural model of the access rules.

module tb_mem_lsu;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] ram [64];
    logic [31:0] model_mem [64];
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic [32:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- RAM model (combinational read, write at edge) ----------------
    assign mem_rdata_i = ram[mem_addr_o[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = init_val(i);
        wr_cnt  = 0;
        wr_addr = '0;
        wr_data = '0;
        forever begin
            @(posedge clk_i);
            if (mem_we_o === 1'b1) begin
                ram[mem_addr_o[7:2]] <= mem_wdata_o;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr_o;
                wr_data <= mem_wdata_o;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_access(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic        err,
        output logic [31:0] rdata,
        output logic        wr,
        output logic [31:0] waddr,
        output logic [31:0] wword,
        output int          lat
    );
        int          off;
        int          idx;
        int          sh;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        off   = int'(addr[1:0]);
        idx   = int'(addr[7:2]);
        word  = model_mem[idx];
        err   = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
        rdata = '0;
        wr    = 1'b0;
        waddr = {addr[31:2], 2'b00};
        wword = '0;
        lat   = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            if (size == 2'd0) begin
                sh = 8 * (3 - off);
                v  = (word >> sh) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                sh = 16 * (1 - off / 2);
                v  = (word >> sh) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
            rdata = v;
        end else begin
            wr = 1'b1;
            if (size == 2'd2) begin
                lat   = 2;
                wword = wdata;
            end else begin
                lat = 3;
                if (size == 2'd0) begin
                    mask = 32'hFF;
                    sh   = 8 * (3 - off);
                end else begin
                    mask = 32'hFFFF;
                    sh   = 16 * (1 - off / 2);
                end
                wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            end
            model_mem[idx] = wword;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int waits;
        waits = 0;
        while (req_ready_o !== 1'b1 && waits < 20) begin
            @(negedge clk_i);
            waits++;
        end
        if (req_ready_o !== 1'b1) check("ready_timeout", 32'(req_ready_o), 32'd1);
    endtask

    task automatic drive_junk();
        req_valid_i    = 1'b1;
        req_we_i       = 1'($urandom_range(0, 1));
        req_size_i     = 2'($urandom_range(0, 3));
        req_unsigned_i = 1'($urandom_range(0, 1));
        req_addr_i     = $urandom;
        req_wdata_i    = $urandom;
    endtask

    // Issue one request, follow it to its response and check it. With hold
    // set, req_valid_i stays high with unrelated requests while busy.
    task automatic send(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  bit          hold,
        output logic [31:0] o_rdata,
        output logic [31:0] o_wdata
    );
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_wr;
        logic [31:0] e_waddr;
        logic [31:0] e_wword;
        int          e_lat;
        int          wr0;
        int          lat;
        bit          got;
        bit          busy_bad;
        logic [32:0] exp;
        o_rdata = '0;
        o_wdata = '0;
        wait_ready();
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        wr0 = wr_cnt;
        model_access(we, size, uns, addr, wdata, e_err, e_rdata, e_wr, e_waddr, e_wword, e_lat);
        exp_q.push_back({e_err, e_rdata});
        @(posedge clk_i);
        lat      = 0;
        got      = 1'b0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk_i);
            if (hold) drive_junk();
            else req_valid_i = 1'b0;
            if (req_ready_o !== 1'b0) busy_bad = 1'b1;
            if (rsp_valid_o === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        exp = exp_q.pop_front();
        check("latency", 32'(lat), 32'(e_lat));
        check("ready_low_busy", 32'(busy_bad), 32'd0);
        if (got) begin
            check("rsp_err", 32'(rsp_err_o), 32'(exp[32]));
            check("rsp_rdata", rsp_rdata_o, exp[31:0]);
            o_rdata = rsp_rdata_o;
        end
        check("we_pulses", 32'(wr_cnt - wr0), 32'(e_wr));
        if (e_wr && (wr_cnt - wr0) == 1) begin
            check("wr_addr", wr_addr, e_waddr);
            check("wr_data", wr_data, e_wword);
            o_wdata = wr_data;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] a;
        logic [1:0]  sz;
        int          wr0;
        int          rsp_cnt;

        for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
        rst_ni         = 1'b0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        repeat (2) @(negedge clk_i);

        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Word store then word load.
        send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, wd);
        check("word_store_data", wd, 32'hDEAD_BEEF);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
        check("word_load_data", rd, 32'hDEAD_BEEF);

        // Byte store merges into the existing word.
        send(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055, 1'b0, rd, wd);
        check("byte_store_merge", wd, 32'hDE55_BEEF);

        // Sign / zero extension.
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F0_7F01, 1'b0, rd, wd);
        send(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 1'b0, rd, wd);
        check("lb_signed", rd, 32'hFFFF_FF80);
        send(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 1'b0, rd, wd);
        check("lb_unsigned", rd, 32'h0000_0080);
        send(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, rd, wd);
        check("lh_22_signed", rd, 32'h0000_7F01);
        send(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0, rd, wd);
        check("lh_20_signed", rd, 32'hFFFF_80F0);

        // Errors: misaligned half, misaligned word, reserved size.
        send(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 1'b0, rd, wd);
        send(1'b1, 2'd2, 1'b0, 32'h26, 32'h1234_5678, 1'b0, rd, wd);
        send(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 1'b0, rd, wd);

        // Reset asserted in the WRITE cycle of a half store to 0x40.
        wait_ready();
        req_valid_i    = 1'b1;
        req_we_i       = 1'b1;
        req_size_i     = 2'd1;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h40;
        req_wdata_i    = 32'h0000_A5C3;
        wr0 = wr_cnt;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("abort_read_we", 32'(mem_we_o), 32'd0);
        @(negedge clk_i);
        check("abort_write_we", 32'(mem_we_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("abort_we_async_drop", 32'(mem_we_o), 32'd0);
        check("abort_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        rsp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid_o === 1'b1) rsp_cnt++;
            @(negedge clk_i);
        end
        check("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("abort_ram_kept", ram[16], model_mem[16]);
        send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, rd, wd);

        // Randomized traffic, mostly aligned.
        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, rd, wd);
        end

        // Valid held high with changing requests while busy.
        for (int n = 0; n < 25; n++) begin
            sz = 2'($urandom_range(0, 2));
            a  = {24'h0, 8'($urandom_range(0, 255))};
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, rd, wd);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
